// File: rtl/address_parser_pkg.sv
// Shared cache geometry, trace command codes and the parsed-address record
// used by the address_parser front-end.
package mypkg;

  localparam int OFFSET_BITS = 6;
  localparam int INDEX_BITS  = 14;
  localparam int TAG_BITS    = 12;
  localparam int ADDR_BITS   = 32;

  typedef enum logic [3:0] {
    CMD_L1_DATA_RD  = 4'd0,
    CMD_L1_DATA_WR  = 4'd1,
    CMD_L1_INSTR_RD = 4'd2,
    CMD_SNOOP_INV   = 4'd3,
    CMD_SNOOP_RD    = 4'd4,
    CMD_SNOOP_WR    = 4'd5,
    CMD_SNOOP_RWIM  = 4'd6,
    CMD_CLEAR       = 4'd8,
    CMD_PRINT       = 4'd9
  } cmd_e;

  typedef struct packed {
    logic [TAG_BITS-1:0]    tag;
    logic [INDEX_BITS-1:0]  index;
    logic [OFFSET_BITS-1:0] byte_select;
  } parsed_addr_t;

  function automatic logic cmd_is_legal(input logic [3:0] code);
    logic legal;
    case (code)
      CMD_L1_DATA_RD, CMD_L1_DATA_WR, CMD_L1_INSTR_RD,
      CMD_SNOOP_INV, CMD_SNOOP_RD, CMD_SNOOP_WR, CMD_SNOOP_RWIM,
      CMD_CLEAR, CMD_PRINT: legal = 1'b1;
      default:              legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/address_parser_if.sv
// Trace-record input channel and parsed-record output channel of address_parser.
// slave = the parser's view, master = the driver/consumer side.
interface address_parser_if #(
  parameter int ADDR_BITS   = mypkg::ADDR_BITS,
  parameter int OFFSET_BITS = mypkg::OFFSET_BITS,
  parameter int INDEX_BITS  = mypkg::INDEX_BITS,
  parameter int TAG_BITS    = mypkg::TAG_BITS
);

  logic                   in_valid;
  logic                   in_ready;
  logic [3:0]             in_cmd;
  logic [ADDR_BITS-1:0]   in_address;
  logic                   out_valid;
  logic                   out_ready;
  logic [3:0]             out_cmd;
  logic [TAG_BITS-1:0]    tag;
  logic [INDEX_BITS-1:0]  index;
  logic [OFFSET_BITS-1:0] byte_select;
  logic [ADDR_BITS-1:0]   line_address;
  logic                   cmd_err;

  modport slave (
    input  in_valid, in_cmd, in_address, out_ready,
    output in_ready, out_valid, out_cmd, tag, index, byte_select,
           line_address, cmd_err
  );

  modport master (
    output in_valid, in_cmd, in_address, out_ready,
    input  in_ready, out_valid, out_cmd, tag, index, byte_select,
           line_address, cmd_err
  );

endinterface

// File: rtl/address_parser_field_split.sv
// Combinational slicer: splits a byte address into tag/index/offset,
// derives the line address and flags illegal command codes.
module address_field_split
  import mypkg::*;
#(
  parameter int ADDR_BITS   = mypkg::ADDR_BITS,
  parameter int OFFSET_BITS = mypkg::OFFSET_BITS,
  parameter int INDEX_BITS  = mypkg::INDEX_BITS,
  parameter int TAG_BITS    = mypkg::TAG_BITS
) (
  input  logic [3:0]             cmd,
  input  logic [ADDR_BITS-1:0]   address,
  output logic [TAG_BITS-1:0]    tag,
  output logic [INDEX_BITS-1:0]  index,
  output logic [OFFSET_BITS-1:0] byte_select,
  output logic [ADDR_BITS-1:0]   line_address,
  output logic                   cmd_err
);

  assign tag          = address[ADDR_BITS-1 -: TAG_BITS];
  assign index        = address[OFFSET_BITS +: INDEX_BITS];
  assign byte_select  = address[OFFSET_BITS-1:0];
  assign line_address = {address[ADDR_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign cmd_err      = !cmd_is_legal(cmd);

endmodule

// File: rtl/address_parser.sv
// Address parser pipeline stage: slices each trace record at capture time and
// holds it in a 2-entry skid buffer so one record per clock survives back-pressure.
module address_parser
  import mypkg::*;
#(
  parameter int ADDR_BITS   = mypkg::ADDR_BITS,
  parameter int OFFSET_BITS = mypkg::OFFSET_BITS,
  parameter int INDEX_BITS  = mypkg::INDEX_BITS,
  parameter int TAG_BITS    = mypkg::TAG_BITS
) (
  input  logic           clk,
  input  logic           rst_n,
  address_parser_if.slave bus
);

  if (ADDR_BITS != TAG_BITS + INDEX_BITS + OFFSET_BITS) begin : g_geom_err
    $error("address_parser: ADDR_BITS must equal TAG_BITS + INDEX_BITS + OFFSET_BITS");
  end

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  typedef struct packed {
    logic [3:0]             cmd;
    logic                   err;
    logic [TAG_BITS-1:0]    tag;
    logic [INDEX_BITS-1:0]  index;
    logic [OFFSET_BITS-1:0] byte_select;
    logic [ADDR_BITS-1:0]   line_address;
  } entry_t;

  logic [1:0] state_q, state_d;
  entry_t     head_q, head_d;   // oldest entry, drives the outputs directly
  entry_t     tail_q, tail_d;
  entry_t     new_entry;
  logic       accept, pop;

  address_field_split #(
    .ADDR_BITS  (ADDR_BITS),
    .OFFSET_BITS(OFFSET_BITS),
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_split (
    .cmd         (bus.in_cmd),
    .address     (bus.in_address),
    .tag         (new_entry.tag),
    .index       (new_entry.index),
    .byte_select (new_entry.byte_select),
    .line_address(new_entry.line_address),
    .cmd_err     (new_entry.err)
  );
  assign new_entry.cmd = bus.in_cmd;

  assign bus.in_ready  = (state_q != ST_FULL);
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign accept        = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          head_d  = new_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          head_d = new_entry;
        end else if (accept) begin
          tail_d  = new_entry;
          state_d = ST_FULL;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only a pop can happen
        if (pop) begin
          head_d  = tail_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign bus.out_cmd      = head_q.cmd;
  assign bus.cmd_err      = head_q.err;
  assign bus.tag          = head_q.tag;
  assign bus.index        = head_q.index;
  assign bus.byte_select  = head_q.byte_select;
  assign bus.line_address = head_q.line_address;

endmodule

// File: tb/tb_address_parser.sv
// Directed + randomized bench for address_parser, scoreboarded against a
// queue-based reference model that derives fields with plain arithmetic.
module tb_address_parser;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] addr;
  } rec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  rec_t model_q[$];

  address_parser_if bus ();

  address_parser dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
  endtask

  // Reference fields computed from the address by arithmetic, not slicing.
  task automatic chk_head(input string name, input rec_t r);
    longint unsigned a;
    a = longint'(r.addr);
    chk({name, ".out_cmd"},      64'(bus.out_cmd),      64'(r.cmd));
    chk({name, ".tag"},          64'(bus.tag),          a / 1048576);
    chk({name, ".index"},        64'(bus.index),        (a / 64) % 16384);
    chk({name, ".byte_select"},  64'(bus.byte_select),  a % 64);
    chk({name, ".line_address"}, 64'(bus.line_address), a - (a % 64));
    chk({name, ".cmd_err"},      64'(bus.cmd_err),      64'((r.cmd == 4'd7) || (r.cmd >= 4'd10)));
  endtask

  // One clock: check handshake and head against the model, then advance both.
  task automatic step(input string name);
    bit   acc, pop;
    rec_t r;
    chk({name, ".in_ready"},  64'(bus.in_ready),  64'(model_q.size() < 2));
    chk({name, ".out_valid"}, 64'(bus.out_valid), 64'(model_q.size() > 0));
    if (model_q.size() > 0) chk_head(name, model_q[0]);
    acc = bus.in_valid && (model_q.size() < 2);
    pop = bus.out_ready && (model_q.size() > 0);
    r.cmd  = bus.in_cmd;
    r.addr = bus.in_address;
    @(posedge clk);
    if (pop) void'(model_q.pop_front());
    if (acc) model_q.push_back(r);
    @(negedge clk);
    $display("step %-10s acc=%0d pop=%0d cmd=%0d addr=%08h depth=%0d",
             name, acc, pop, r.cmd, r.addr, model_q.size());
  endtask

  task automatic send_one(input string name, input logic [3:0] cmd, input logic [31:0] addr);
    bus.in_valid   = 1'b1;
    bus.in_cmd     = cmd;
    bus.in_address = addr;
    bus.out_ready  = 1'b1;
    step(name);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_cmd     = 4'd0;
    bus.in_address = 32'd0;
    bus.out_ready  = 1'b0;

    // Reset values while held in reset
    repeat (2) @(negedge clk);
    chk("rst.in_ready",     64'(bus.in_ready),     64'd1);
    chk("rst.out_valid",    64'(bus.out_valid),    64'd0);
    chk("rst.out_cmd",      64'(bus.out_cmd),      64'd0);
    chk("rst.tag",          64'(bus.tag),          64'd0);
    chk("rst.index",        64'(bus.index),        64'd0);
    chk("rst.byte_select",  64'(bus.byte_select),  64'd0);
    chk("rst.line_address", 64'(bus.line_address), 64'd0);
    chk("rst.cmd_err",      64'(bus.cmd_err),      64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed split with literal expectations, one cycle latency
    send_one("split", 4'd0, 32'h1234_5678);
    chk("split.out_valid",    64'(bus.out_valid),    64'd1);
    chk("split.tag",          64'(bus.tag),          64'h123);
    chk("split.index",        64'(bus.index),        64'h1159);
    chk("split.byte_select",  64'(bus.byte_select),  64'h38);
    chk("split.line_address", 64'(bus.line_address), 64'h1234_5640);
    chk("split.cmd_err",      64'(bus.cmd_err),      64'd0);
    step("split_pop");

    send_one("all_ones", 4'd1, 32'hFFFF_FFFF);
    chk("ones.tag",         64'(bus.tag),          64'hFFF);
    chk("ones.index",       64'(bus.index),        64'h3FFF);
    chk("ones.byte_select", 64'(bus.byte_select),  64'h3F);
    chk("ones.line",        64'(bus.line_address), 64'hFFFF_FFC0);
    step("ones_pop");

    send_one("all_zero", 4'd2, 32'h0000_0000);
    chk("zero.tag",         64'(bus.tag),          64'd0);
    chk("zero.index",       64'(bus.index),        64'd0);
    chk("zero.byte_select", 64'(bus.byte_select),  64'd0);
    chk("zero.line",        64'(bus.line_address), 64'd0);
    step("zero_pop");

    // Command legality
    send_one("cmd7", 4'd7, $urandom);
    chk("cmd7.cmd_err", 64'(bus.cmd_err), 64'd1);
    chk("cmd7.out_cmd", 64'(bus.out_cmd), 64'd7);
    send_one("cmd9", 4'd9, $urandom);
    chk("cmd9.cmd_err", 64'(bus.cmd_err), 64'd0);
    chk("cmd9.out_cmd", 64'(bus.out_cmd), 64'd9);
    send_one("cmd15", 4'd15, $urandom);
    chk("cmd15.cmd_err", 64'(bus.cmd_err), 64'd1);
    chk("cmd15.out_cmd", 64'(bus.out_cmd), 64'd15);
    step("cmd_pop");

    // Back-pressure: three offered, two accepted, then drain in order
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_cmd     = 4'($urandom_range(0, 15));
      bus.in_address = $urandom;
      step("bp_fill");
    end
    chk("bp.in_ready_full", 64'(bus.in_ready), 64'd0);
    bus.in_valid  = 1'b0;
    step("bp_hold");
    bus.out_ready = 1'b1;
    repeat (3) step("bp_drain");
    chk("bp.drained", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset while FULL discards both records at once
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    repeat (2) begin
      bus.in_cmd     = 4'($urandom_range(0, 15));
      bus.in_address = $urandom;
      step("rf_fill");
    end
    bus.in_valid = 1'b0;
    chk("rf.full", 64'(bus.in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rf.out_valid", 64'(bus.out_valid), 64'd0);
    chk("rf.in_ready",  64'(bus.in_ready),  64'd1);
    chk("rf.tag",       64'(bus.tag),       64'd0);
    model_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full-throughput random stream
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.in_cmd     = 4'($urandom_range(0, 15));
      bus.in_address = $urandom;
      step("stream");
      chk("stream.one_per_cycle", 64'(bus.out_valid), 64'd1);
    end
    bus.in_valid = 1'b0;
    step("stream_end");

    // Random valid/ready mix
    for (int i = 0; i < 200; i++) begin
      bus.in_valid   = 1'($urandom_range(0, 1));
      bus.out_ready  = ($urandom_range(0, 3) != 0);
      bus.in_cmd     = 4'($urandom_range(0, 15));
      bus.in_address = $urandom;
      step("mix");
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) step("mix_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/address_parser.md
# address_parser

Front-end pipeline stage of the cache simulator that takes one trace record (command plus 32-bit byte address) per handshake. It splits the address into tag, set index and byte offset per the cache geometry in the shared package, flags illegal commands, and presents the result on a registered valid/ready output to the cache controller. A 2-entry skid buffer lets it sustain one record per clock under back-pressure.

## Interface
- ADDR_BITS, 32, address width; must equal TAG_BITS + INDEX_BITS + OFFSET_BITS (elaboration-time `$error` otherwise)
- OFFSET_BITS, mypkg::OFFSET_BITS (6), byte-select width (64-byte line)
- INDEX_BITS, mypkg::INDEX_BITS (14), set-index width
- TAG_BITS, mypkg::TAG_BITS (12), tag width
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  record present
- in_ready  out  1  stage can accept a record
- in_cmd  in  4  trace command code
- in_address  in  ADDR_BITS  byte address
- out_valid  out  1  parsed record present
- out_ready  in  1  consumer accepts record
- out_cmd  out  4  command, passed through
- tag  out  TAG_BITS  address[ADDR_BITS-1 -: TAG_BITS]
- index  out  INDEX_BITS  address[OFFSET_BITS +: INDEX_BITS]
- byte_select  out  OFFSET_BITS  address[OFFSET_BITS-1:0]
- line_address  out  ADDR_BITS  address with byte_select bits forced to 0
- cmd_err  out  1  out_cmd not a legal code; qualified by out_valid

## Operation
- Legal commands: 0 L1 data read, 1 L1 data write, 2 L1 instruction read, 3 snoop invalidate, 4 snoop read, 5 snoop write, 6 snoop RWIM, 8 clear/reset, 9 print. Codes 7 and 10–15 set cmd_err=1.
- Records with cmd_err are still forwarded; the stage never drops or reorders records.
- Field split is pure bit slicing, performed when the record is captured; outputs come straight from registers.
- Storage is a 2-entry FIFO (skid buffer). States: EMPTY (0 entries), ONE, FULL (2 entries).
- in_ready = not FULL. out_valid = not EMPTY. Outputs show the oldest entry.
- Input accept: in_valid && in_ready. Output pop: out_valid && out_ready.
- Transitions: EMPTY + accept → ONE. ONE + accept + no pop → FULL. ONE + pop + no accept → EMPTY. ONE + accept + pop → ONE, with the new record replacing the old. FULL + pop → ONE. In FULL, no accept is possible.
- A simultaneous accept and pop in ONE is legal every cycle, giving full throughput.

## Timing
- Latency: a record accepted at edge N appears on the outputs with out_valid=1 after edge N, i.e. one cycle.
- in_ready and out_valid are pure functions of state. There is no combinational path from any input to any output.
- Reset (async assert, release sampled on clk): state EMPTY, in_ready=1, out_valid=0. out_cmd, tag, index, byte_select, line_address and cmd_err all reset to 0.
- Reset asserted mid-transfer discards all buffered records immediately.
- Outputs must stay stable while out_valid && !out_ready.

## Structure
- mypkg holds OFFSET_BITS, INDEX_BITS, TAG_BITS, ADDR_BITS, a cmd_e enum for the codes above, and a parsed_addr_t struct {tag, index, byte_select}.
- The sub-module address_field_split is the natural combinational slicer; it is instantiated once at the input.
- The FIFO and its control stay in address_parser.

## Test plan
- Reset: hold rst_n=0 → in_ready=1, out_valid=0, all fields 0. Assert rst_n while FULL → EMPTY at once.
- Split: cmd 0, address 0x1234_5678, out_ready=1 → after 1 cycle tag=0x123, index=0x1159, byte_select=0x38, line_address=0x1234_5640, cmd_err=0.
- Boundaries: address 0xFFFF_FFFF → tag=0xFFF, index=0x3FFF, byte_select=0x3F. Address 0x0000_0000 → all fields 0.
- Commands: send 7, 9, 15 → cmd_err = 1, 0, 1; out_cmd echoes the code each time.
- Back-pressure: hold out_ready=0 and send 3 records → first 2 accepted, in_ready=0 after the second. Release → records drain in order with values unchanged.
- Throughput: stream 100 random records with in_valid=out_ready=1 → one output per cycle after a 1-cycle fill, all matching the bit-slicing model.
